// File: rtl/pc_gen_hs_pkg.sv
// pc_gen_hs_pkg: shared constants and FSM state encoding for the fetch PC generator.
// The optional redirect alignment check is enabled by defining PC_GEN_ALIGN_CHECK_EN.
package pc_gen_hs_pkg;

  // Default PC / fetch address width.
  localparam int BUS_WIDTH = 32;

  // Default PC loaded by reset.
  localparam logic [BUS_WIDTH-1:0] PCG_RESET_PC_DEFAULT = '0;

  // Generator states:
  //   BOOT : the single cycle after reset, before the first request can exist.
  //   RUN  : normal issue, at most one request outstanding.
  //   PEND : a redirect arrived while a request was stalled. That request
  //          stays valid but is stale, and its replacement target waits here.
  typedef enum logic [1:0] {
    PCG_BOOT = 2'd0,
    PCG_RUN  = 2'd1,
    PCG_PEND = 2'd2
  } pcg_state_e;

  // Power-of-two test, used to reject bad INSTR_BYTES values at elaboration.
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/pc_gen_hs_dff.sv
// dff_rst_sync_val: WIDTH-bit register with a synchronous active-high reset
// to RESET_VAL. It is the building block for all pc_gen_hs state.
module dff_rst_sync_val #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load RESET_VAL while rst is high, otherwise capture d.
  always_ff @(posedge clk) begin
    if (rst) q <= RESET_VAL;
    else     q <= d;
  end

endmodule

// File: rtl/pc_gen_hs.sv
// pc_gen_hs: instruction-fetch PC generator with a valid/ready request port.
// It has two prioritised redirect sources (trap over branch) and flags stale
// requests. Optional feature macro: PC_GEN_ALIGN_CHECK_EN. When it is defined,
// misaligned redirect targets are dropped and misalign_err is raised.
//
// Handshake: a request is offered with pc_valid=1 and pc_out. It transfers on
// any rising edge where pc_valid & pc_ready are both 1. While a request is
// offered and not yet taken, pc_valid and pc_out hold steady. A redirect never
// withdraws an offered request; it only raises pc_stale to tell downstream to
// discard the returned instruction.
module pc_gen_hs
  import pc_gen_hs_pkg::*;
#(
  parameter int                  PC_WIDTH    = BUS_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(PCG_RESET_PC_DEFAULT),
  parameter int                  INSTR_BYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trap_valid,
  input  logic [PC_WIDTH-1:0] trap_addr,
  input  logic                branch,
  input  logic [PC_WIDTH-1:0] branch_addr,
  input  logic                hold,
  input  logic                pc_ready,
  output logic                pc_valid,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                pc_stale,
  output logic                misalign_err,
  output logic [1:0]          dbg_state
);

  localparam logic [PC_WIDTH-1:0] INC = PC_WIDTH'(INSTR_BYTES);

  // Reject an increment that is not a power of two at elaboration time.
  if (!is_pow2(INSTR_BYTES)) begin : g_bad_incr
    $error("pc_gen_hs: INSTR_BYTES must be a power of two");
  end

  // Registered state.
  logic [1:0]          state_raw;
  logic [1:0]          state_n;
  pcg_state_e          state_q;
  logic [PC_WIDTH-1:0] pc_q,    pc_n;
  logic [PC_WIDTH-1:0] pend_q,  pend_n;
  logic                valid_q, valid_n;
  logic                stale_q, stale_n;

  // Redirect decode.
  logic                redir_raw;
  logic                redir;
  logic [PC_WIDTH-1:0] tgt;
  logic                fire;

  // Trap wins over branch when both redirect in the same cycle.
  assign redir_raw = trap_valid | branch;
  assign tgt       = trap_valid ? trap_addr : branch_addr;
  assign fire      = valid_q & pc_ready;
  assign state_q   = pcg_state_e'(state_raw);

`ifdef PC_GEN_ALIGN_CHECK_EN
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'(INSTR_BYTES - 1);
  logic tgt_misaligned;
  logic err_q;

  // The priority-selected target is the one tested. A misaligned trap is
  // dropped; the branch is not used in its place.
  assign tgt_misaligned = |(tgt & ALIGN_MASK);
  assign redir          = redir_raw & ~tgt_misaligned;

  dff_rst_sync_val #(.WIDTH(1), .RESET_VAL(1'b0)) u_err_reg (
    .clk (clk),
    .rst (rst),
    .d   (redir_raw & tgt_misaligned),
    .q   (err_q)
  );
  assign misalign_err = err_q;
`else
  assign redir        = redir_raw;
  assign misalign_err = 1'b0;
`endif

  // Next-state logic for the issue FSM, the fetch address and the pending target.
  always_comb begin
    state_n = state_raw;
    pc_n    = pc_q;
    pend_n  = pend_q;
    valid_n = valid_q;
    stale_n = stale_q;
    unique case (state_q)
      PCG_BOOT: begin
        if (redir) pc_n = tgt;
        valid_n = ~hold;
        stale_n = 1'b0;
        state_n = PCG_RUN;
      end
      PCG_RUN: begin
        if (!valid_q) begin
          if (redir) pc_n = tgt;
          valid_n = ~hold;
        end else if (fire) begin
          pc_n    = redir ? tgt : pc_q + INC;
          valid_n = ~hold;
        end else if (redir) begin
          // The stalled request stays offered; its successor is parked.
          pend_n  = tgt;
          stale_n = 1'b1;
          state_n = PCG_PEND;
        end
      end
      PCG_PEND: begin
        if (fire) begin
          // A redirect in the same cycle is newer than the parked target.
          pc_n    = redir ? tgt : pend_q;
          stale_n = 1'b0;
          valid_n = ~hold;
          state_n = PCG_RUN;
        end else if (redir) begin
          pend_n = tgt;
        end
      end
      default: begin
        // Illegal encoding: fall back to RUN with no request outstanding.
        valid_n = 1'b0;
        stale_n = 1'b0;
        state_n = PCG_RUN;
      end
    endcase
  end

  dff_rst_sync_val #(.WIDTH(2), .RESET_VAL(PCG_BOOT)) u_state_reg (
    .clk (clk),
    .rst (rst),
    .d   (state_n),
    .q   (state_raw)
  );

  dff_rst_sync_val #(.WIDTH(PC_WIDTH), .RESET_VAL(RESET_PC)) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .d   (pc_n),
    .q   (pc_q)
  );

  dff_rst_sync_val #(.WIDTH(PC_WIDTH), .RESET_VAL('0)) u_pend_reg (
    .clk (clk),
    .rst (rst),
    .d   (pend_n),
    .q   (pend_q)
  );

  dff_rst_sync_val #(.WIDTH(1), .RESET_VAL(1'b0)) u_valid_reg (
    .clk (clk),
    .rst (rst),
    .d   (valid_n),
    .q   (valid_q)
  );

  dff_rst_sync_val #(.WIDTH(1), .RESET_VAL(1'b0)) u_stale_reg (
    .clk (clk),
    .rst (rst),
    .d   (stale_n),
    .q   (stale_q)
  );

  assign pc_valid  = valid_q;
  assign pc_out    = pc_q;
  assign pc_stale  = stale_q;
  assign dbg_state = state_raw;

endmodule

// File: tb/tb_pc_gen_hs.sv
// tb_pc_gen_hs: bench for pc_gen_hs. It runs directed scenarios, then a
// random run, against a transaction-level model of the fetch request stream.
module tb_pc_gen_hs;

  localparam int          PCW    = 32;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam int          INCR   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            trap_valid = 1'b0;
  logic [PCW-1:0]  trap_addr = '0;
  logic            branch = 1'b0;
  logic [PCW-1:0]  branch_addr = '0;
  logic            hold = 1'b0;
  logic            pc_ready = 1'b0;
  logic            pc_valid;
  logic [PCW-1:0]  pc_out;
  logic            pc_stale;
  logic            misalign_err;
  logic [1:0]      dbg_state;

  int total = 0;
  int bad   = 0;

  // Model: the offered request, whether the cycle after reset is still to
  // come, and a queue holding the replacement target (empty when none waits).
  bit              m_first;
  logic [PCW-1:0]  m_pc;
  bit              m_valid;
  bit              m_err;
  logic [PCW-1:0]  m_pend_q[$];

  // Clock and DUT.
  always #5 clk = ~clk;

  pc_gen_hs #(.PC_WIDTH(PCW), .RESET_PC(RST_PC), .INSTR_BYTES(INCR)) dut (
    .clk          (clk),
    .rst          (rst),
    .trap_valid   (trap_valid),
    .trap_addr    (trap_addr),
    .branch       (branch),
    .branch_addr  (branch_addr),
    .hold         (hold),
    .pc_ready     (pc_ready),
    .pc_valid     (pc_valid),
    .pc_out       (pc_out),
    .pc_stale     (pc_stale),
    .misalign_err (misalign_err),
    .dbg_state    (dbg_state)
  );

  // Advance the model by one clock edge using the inputs just driven.
  task automatic model_edge();
    bit             fire;
    bit             raw;
    bit             take;
    bit             mis;
    logic [PCW-1:0] tgt;
    fire = m_valid && pc_ready;
    raw  = trap_valid || branch;
    tgt  = trap_valid ? trap_addr : branch_addr;
    mis  = (tgt % INCR) != 0;
`ifdef PC_GEN_ALIGN_CHECK_EN
    take = raw && !mis;
`else
    take = raw;
`endif
    if (rst) begin
      m_pc = RST_PC; m_valid = 0; m_err = 0; m_first = 1; m_pend_q.delete();
      return;
    end
`ifdef PC_GEN_ALIGN_CHECK_EN
    m_err = raw && mis;
`else
    m_err = 0;
`endif
    if (m_first) begin
      m_first = 0;
      if (take) m_pc = tgt;
      m_valid = !hold;
    end else if (m_pend_q.size() != 0) begin
      if (fire) begin
        m_pc = take ? tgt : m_pend_q[0];
        m_pend_q.delete();
        m_valid = !hold;
      end else if (take) begin
        m_pend_q[0] = tgt;
      end
    end else if (!m_valid) begin
      if (take) m_pc = tgt;
      m_valid = !hold;
    end else if (fire) begin
      m_pc = take ? tgt : PCW'(m_pc + INCR);
      m_valid = !hold;
    end else if (take) begin
      m_pend_q.push_back(tgt);
    end
  endtask

  // Driver: apply one cycle of inputs, clock, then check every output.
  task automatic step(input string name, input bit r, input bit rdy, input bit hld,
                      input bit tv, input logic [PCW-1:0] ta,
                      input bit br, input logic [PCW-1:0] ba);
    rst = r; pc_ready = rdy; hold = hld;
    trap_valid = tv; trap_addr = ta; branch = br; branch_addr = ba;
    @(posedge clk);
    model_edge();
    #1;
    total++;
    if (pc_valid !== m_valid) begin
      bad++; $display("FAIL %s pc_valid got %b want %b", name, pc_valid, m_valid);
    end
    total++;
    if (pc_out !== m_pc) begin
      bad++; $display("FAIL %s pc_out got %h want %h", name, pc_out, m_pc);
    end
    total++;
    if (pc_stale !== (m_pend_q.size() != 0)) begin
      bad++; $display("FAIL %s pc_stale got %b want %b", name, pc_stale, m_pend_q.size() != 0);
    end
    total++;
    if (misalign_err !== m_err) begin
      bad++; $display("FAIL %s misalign_err got %b want %b", name, misalign_err, m_err);
    end
  endtask

  // Plain cycle with no redirect.
  task automatic idle(input string name, input bit rdy, input bit hld);
    step(name, 0, rdy, hld, 0, '0, 0, '0);
  endtask

  task automatic test_reset();
    step("reset", 1, 1, 0, 0, '0, 0, '0);
    total++;
    if (pc_valid !== 1'b0 || pc_out !== RST_PC || pc_stale !== 1'b0) begin
      bad++; $display("FAIL reset_const valid=%b pc=%h stale=%b want 0 %h 0",
                      pc_valid, pc_out, pc_stale, RST_PC);
    end
  endtask

  task automatic test_sequential();
    logic [PCW-1:0] seen[4];
    logic [PCW-1:0] want[4];
    want = '{32'h0, 32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 4; i++) begin
      idle("seq", 1, 0);
      seen[i] = pc_out;
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (seen[i] !== want[i]) begin
        bad++; $display("FAIL seq_const[%0d] pc_out got %h want %h", i, seen[i], want[i]);
      end
    end
  endtask

  task automatic test_hold_stall();
    idle("stall_pre", 0, 0);
    idle("stall_pre", 1, 0);
    idle("stall", 0, 0);
    idle("stall_hold", 0, 1);
    idle("stall", 0, 0);
    total++;
    if (pc_valid !== 1'b1 || pc_out !== 32'h10) begin
      bad++; $display("FAIL stall_const valid=%b pc=%h want 1 00000010", pc_valid, pc_out);
    end
    idle("stall_go", 1, 0);
    total++;
    if (pc_out !== 32'h14) begin
      bad++; $display("FAIL stall_next pc_out got %h want 00000014", pc_out);
    end
  endtask

  task automatic test_redirect_pend();
    step("pend_setup", 0, 1, 0, 0, '0, 1, 32'h20);
    step("pend_br", 0, 0, 0, 0, '0, 1, 32'h100);
    step("pend_trap", 0, 0, 0, 1, 32'h80, 0, '0);
    total++;
    if (pc_stale !== 1'b1 || pc_out !== 32'h20) begin
      bad++; $display("FAIL pend_stale stale=%b pc=%h want 1 00000020", pc_stale, pc_out);
    end
    idle("pend_fire", 1, 0);
    total++;
    if (pc_out !== 32'h80 || pc_stale !== 1'b0) begin
      bad++; $display("FAIL pend_fire_const pc=%h stale=%b want 00000080 0", pc_out, pc_stale);
    end
  endtask

  task automatic test_same_cycle_redirect();
    step("prio", 0, 1, 0, 1, 32'h200, 1, 32'h300);
    total++;
    if (pc_out !== 32'h200) begin
      bad++; $display("FAIL prio_const pc_out got %h want 00000200", pc_out);
    end
  endtask

  task automatic test_wrap();
    step("wrap_setup", 0, 1, 0, 0, '0, 1, 32'hFFFF_FFFC);
    idle("wrap", 1, 0);
    total++;
    if (pc_out !== 32'h0) begin
      bad++; $display("FAIL wrap_const pc_out got %h want 00000000", pc_out);
    end
  endtask

  task automatic test_reset_mid_handshake();
    idle("mid_pre", 0, 0);
    step("mid_rst", 1, 0, 0, 0, '0, 0, '0);
    total++;
    if (pc_valid !== 1'b0 || pc_out !== RST_PC) begin
      bad++; $display("FAIL mid_rst_const valid=%b pc=%h want 0 %h", pc_valid, pc_out, RST_PC);
    end
    idle("mid_boot", 1, 0);
  endtask

  task automatic test_misalign();
    idle("mis_pre", 1, 0);
    step("mis_br", 0, 1, 0, 0, '0, 1, 32'h102);
`ifdef PC_GEN_ALIGN_CHECK_EN
    total++;
    if (pc_out === 32'h102 || misalign_err !== 1'b1) begin
      bad++; $display("FAIL mis_const pc=%h err=%b want sequential 1", pc_out, misalign_err);
    end
`else
    total++;
    if (pc_out !== 32'h102 || misalign_err !== 1'b0) begin
      bad++; $display("FAIL mis_const pc=%h err=%b want 00000102 0", pc_out, misalign_err);
    end
`endif
    idle("mis_after", 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit             r, rdy, hld, tv, br;
      logic [PCW-1:0] ta, ba;
      r   = ($urandom_range(0, 39) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      hld = ($urandom_range(0, 3) == 0);
      tv  = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 5) == 0);
      ta  = $urandom();
      ba  = $urandom();
      if ($urandom_range(0, 4) != 0) ta[1:0] = 2'b00;
      if ($urandom_range(0, 4) != 0) ba[1:0] = 2'b00;
      step("random", r, rdy, hld, tv, ta, br, ba);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold_stall();
    test_redirect_pend();
    test_same_cycle_redirect();
    test_wrap();
    test_reset_mid_handshake();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
